// File: rtl/act_vec_writer_pkg.sv
// Shared definitions for the activation-vector writer: FSM encoding,
// default geometry and the lane-slice helper used by the activation array.
package act_vec_writer_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ARRAY_SIZE = 9;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // LSB position of lane 'lane' inside a packed vector of 'width'-bit lanes
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/act_vec_writer_if.sv
// Vector input stream plus single-word feature-map write port.
interface act_vec_writer_if
    import act_vec_writer_pkg::*;
#(
    parameter int unsigned data_width = DEF_DATA_WIDTH,
    parameter int unsigned array_size = DEF_ARRAY_SIZE,
    parameter int unsigned addr_width = DEF_ADDR_WIDTH
) ();

    logic                           in_valid;
    logic                           in_ready;
    logic [array_size-1:0]          in_en;
    logic [data_width*array_size-1:0] in_data;

    logic                           mem_we;
    logic [addr_width-1:0]          mem_addr;
    logic [data_width-1:0]          mem_wdata;
    logic                           mem_ready;

    // Producer of vectors and owner of the memory port
    modport master (
        output in_valid, in_en, in_data, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // The writer block itself
    modport slave (
        input  in_valid, in_en, in_data, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/act_vec_writer_vec_fifo.sv
// Synchronous vector FIFO with registered count/full/empty and a
// combinational head read (rdata_c).
module vec_fifo #(
    parameter int unsigned width = 81,
    parameter int unsigned depth = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [width-1:0]               wdata,
    input  logic                           pop,
    output logic [width-1:0]               rdata_c,
    output logic [$clog2(depth+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata_c = mem[rd_ptr];

    // Pointers wrap naturally because depth is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_w'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_w'(1);
            case ({do_push, do_pop})
                2'b10: begin
                    count <= count + cnt_w'(1);
                    full  <= (count == cnt_w'(depth - 1));
                    empty <= 1'b0;
                end
                2'b01: begin
                    count <= count - cnt_w'(1);
                    full  <= 1'b0;
                    empty <= (count == cnt_w'(1));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/act_vec_writer.sv
// Buffers activation vectors and serializes them one lane per cycle onto a
// single-word feature-map write port with an auto-incrementing address.
module act_vec_writer
    import act_vec_writer_pkg::*;
#(
    parameter int unsigned data_width = DEF_DATA_WIDTH,
    parameter int unsigned array_size = DEF_ARRAY_SIZE,
    parameter int unsigned fifo_depth = DEF_FIFO_DEPTH,
    parameter int unsigned addr_width = DEF_ADDR_WIDTH,
    parameter int unsigned cnt_width  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [cnt_width-1:0]  num_vecs,
    act_vec_writer_if.slave       bus,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned vec_w  = data_width * array_size;
    localparam int unsigned ent_w  = vec_w + array_size;
    localparam int unsigned lane_w = (array_size > 1) ? $clog2(array_size) : 1;
    localparam int unsigned fcnt_w = $clog2(fifo_depth + 1);

    state_t                state;
    logic [addr_width-1:0] job_base;
    logic [cnt_width-1:0]  job_len;
    logic [cnt_width-1:0]  acc_cnt;
    logic [addr_width-1:0] word_cnt;
    logic [lane_w-1:0]     lane_idx;

    logic [ent_w-1:0]      head;
    logic [fcnt_w-1:0]     fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic                  push;
    logic                  consume;
    logic                  pop;
    logic                  last_pop;
    logic [fcnt_w-1:0]     fifo_cnt_next;
    logic [cnt_width-1:0]  acc_next;
    logic                  room_next;
    logic [data_width-1:0] lane_data;
    logic                  lane_en;

    vec_fifo #(
        .width (ent_w),
        .depth (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wdata   ({bus.in_en, bus.in_data}),
        .pop     (pop),
        .rdata_c (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Handshake, serializer strobes and look-ahead values for in_ready
    always_comb begin
        push     = bus.in_valid && bus.in_ready && !fifo_full;
        consume  = ((state == ST_RUN) || (state == ST_DRAIN)) && !fifo_empty && bus.mem_ready;
        pop      = consume && (lane_idx == lane_w'(array_size - 1));
        last_pop = pop && (fifo_count == fcnt_w'(1)) && (acc_cnt == job_len);

        fifo_cnt_next = fifo_count;
        if (push && !pop)      fifo_cnt_next = fifo_count + fcnt_w'(1);
        else if (pop && !push) fifo_cnt_next = fifo_count - fcnt_w'(1);

        acc_next  = push ? (acc_cnt + cnt_width'(1)) : acc_cnt;
        room_next = (fifo_cnt_next < fcnt_w'(fifo_depth)) && (acc_next < job_len);
    end

    // Head-vector lane select
    always_comb begin
        lane_data = '0;
        lane_en   = 1'b0;
        for (int i = 0; i < int'(array_size); i++) begin
            if (lane_idx == lane_w'(i)) begin
                lane_data = head[lane_lsb(i, data_width) +: data_width];
                lane_en   = head[vec_w + i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            job_base      <= '0;
            job_len       <= '0;
            acc_cnt       <= '0;
            word_cnt      <= '0;
            lane_idx      <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done         <= 1'b0;
            bus.in_ready <= 1'b0;

            if (push) acc_cnt <= acc_next;

            // Output register advances only when the memory takes the slot
            if (bus.mem_ready) begin
                if (consume) begin
                    bus.mem_we    <= lane_en;
                    bus.mem_addr  <= job_base + word_cnt;
                    bus.mem_wdata <= lane_data;
                    word_cnt      <= word_cnt + addr_width'(1);
                    lane_idx      <= pop ? '0 : (lane_idx + lane_w'(1));
                end else begin
                    bus.mem_we <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        job_base <= base_addr;
                        job_len  <= num_vecs;
                        acc_cnt  <= '0;
                        word_cnt <= '0;
                        lane_idx <= '0;
                        if (num_vecs != '0) begin
                            state        <= ST_RUN;
                            busy         <= 1'b1;
                            bus.in_ready <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (acc_cnt == job_len) begin
                        if (last_pop) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        bus.in_ready <= room_next;
                    end
                end
                ST_DRAIN: begin
                    if (last_pop) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_act_vec_writer.sv
// Scoreboard bench for act_vec_writer: directed jobs push expected writes,
// a negedge monitor pops and compares every accepted memory write.
module tb_act_vec_writer;

    localparam int unsigned DW = 8;
    localparam int unsigned AS = 9;
    localparam int unsigned AW = 12;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_vecs = '0;
    logic          busy;
    logic          done;

    act_vec_writer_if #(.data_width(DW), .array_size(AS), .addr_width(AW)) bus ();

    act_vec_writer #(
        .data_width (DW),
        .array_size (AS),
        .fifo_depth (4),
        .addr_width (AW),
        .cnt_width  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_vecs  (num_vecs),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            last_wr_cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic [AW-1:0] exp_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor: every accepted write must match the head of the expectation queue
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_we && bus.mem_ready) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected (cycle %0d)",
                             bus.mem_addr, bus.mem_wdata, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                    check("wr_data", 32'(bus.mem_wdata), 32'(mon_e.data));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [CW-1:0] n, output int scyc);
        tick();
        start     = 1'b1;
        base_addr = base;
        num_vecs  = n;
        exp_addr  = base;
        scyc      = cyc;
        tick();
        start     = 1'b0;
    endtask

    // Lane i carries first+i; enabled lanes become expected writes
    task automatic push_vec(input logic [DW-1:0] first, input logic [AS-1:0] en);
        logic [DW-1:0] v;
        wr_t           w;
        int            k;
        for (int i = 0; i < int'(AS); i++) begin
            v = first + DW'(i);
            bus.in_data[i*DW +: DW] = v;
            if (en[i]) begin
                w.addr = exp_addr;
                w.data = v;
                exp_q.push_back(w);
            end
            exp_addr = exp_addr + AW'(1);
        end
        bus.in_en    = en;
        bus.in_valid = 1'b1;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (k == 300) fail_now("push_accept");
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_wr_addr(input logic [AW-1:0] a);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.mem_we && bus.mem_ready && bus.mem_addr == a) break;
        end
        if (k == 300) fail_now("wait_write_addr");
    endtask

    task automatic wait_done(input int n_writes, input int w0);
        int c0 = done_cnt;
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (done_cnt > c0) break;
        end
        if (k == 500) fail_now("wait_done");
        else check("done_after_last_write", 32'(done_cyc - last_wr_cyc), 32'd1);
        repeat (3) @(negedge clk);
        check("done_single_pulse", 32'(done_cnt - c0), 32'd1);
        check("write_count", 32'(wr_cnt - w0), 32'(n_writes));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int w0;
        int c0;
        bus.in_valid  = 1'b0;
        bus.in_en     = '0;
        bus.in_data   = '0;
        bus.mem_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;

        // Two full vectors at 0x100
        w0 = wr_cnt;
        start_job(12'h100, 16'd2, s);
        check("busy_in_run", 32'(busy), 32'd1);
        push_vec(8'd1, 9'h1FF);
        push_vec(8'd11, 9'h1FF);
        wait_done(18, w0);

        // Alternating lane mask
        w0 = wr_cnt;
        start_job(12'h020, 16'd1, s);
        push_vec(8'hA0, 9'b1_0101_0101);
        wait_done(5, w0);

        // Stall mid-vector at lane 3
        w0 = wr_cnt;
        start_job(12'h040, 16'd1, s);
        push_vec(8'h31, 9'h1FF);
        wait_wr_addr(12'h042);
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_addr", 32'(bus.mem_addr), 32'h043);
            check("stall_wdata", 32'(bus.mem_wdata), 32'h34);
            check("stall_we", 32'(bus.mem_we), 32'd1);
        end
        tick();
        bus.mem_ready = 1'b1;
        wait_done(9, w0);

        // Long stall: FIFO fills after four vectors
        w0 = wr_cnt;
        tick();
        bus.mem_ready = 1'b0;
        start_job(12'h200, 16'd6, s);
        push_vec(8'h50, 9'h1FF);
        push_vec(8'h60, 9'h1FF);
        push_vec(8'h70, 9'h1FF);
        push_vec(8'h80, 9'h1FF);
        bus.in_en    = '1;
        bus.in_valid = 1'b1;
        repeat (8) @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_no_writes", 32'(wr_cnt - w0), 32'd0);
        tick();
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        push_vec(8'h90, 9'h1FF);
        push_vec(8'hA0, 9'h1FF);
        wait_done(54, w0);

        // Empty job
        w0 = wr_cnt;
        c0 = done_cnt;
        start_job(12'h000, 16'd0, s);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("zero_in_ready", 32'(bus.in_ready), 32'd0);
            check("zero_busy", 32'(busy), 32'd0);
        end
        repeat (2) @(negedge clk);
        check("zero_done_count", 32'(done_cnt - c0), 32'd1);
        check("zero_done_cycle", 32'(done_cyc - s), 32'd2);
        check("zero_no_writes", 32'(wr_cnt - w0), 32'd0);

        // Address wrap at the top of the space
        w0 = wr_cnt;
        start_job(12'hFFC, 16'd1, s);
        push_vec(8'hF8, 9'h1FF);
        wait_done(9, w0);

        // Reset during lane 5 of the second vector, then a clean job
        start_job(12'h300, 16'd2, s);
        push_vec(8'h10, 9'h1FF);
        push_vec(8'h20, 9'h1FF);
        wait_wr_addr(12'h30D);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_lanes_pending", 32'(exp_q.size()), 32'd4);
        exp_q.delete();
        @(negedge clk);
        check("post_rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        w0 = wr_cnt;
        start_job(12'h500, 16'd1, s);
        push_vec(8'h61, 9'h1FF);
        wait_done(9, w0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/act_vec_writer.md
Name: act_vec_writer

Overview:
Consumer side of the ReLU activation array. Accepts array_size-lane activation vectors plus a per-lane enable mask through a valid/ready handshake and buffers them in a small vector FIFO. Serializes each vector one lane per cycle onto a single-word feature-map memory write port, with an auto-incrementing address. Sits between the activation stage and the next layer's feature-map buffer.

Parameters:
data_width, 8, bits per activation lane
array_size, 9, lanes per input vector
fifo_depth, 4, vectors buffered (power of 2, >=2)
addr_width, 12, memory address width
cnt_width, 16, width of the vector-count field

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches base_addr and num_vecs; ignored unless state is IDLE
base_addr  in  addr_width  address of the first lane of the first vector
num_vecs  in  cnt_width  vectors in this job
in_valid  in  1  vector present
in_ready  out  1  vector accepted when in_valid && in_ready
in_en  in  array_size  per-lane write mask; lane i maps to bit i
in_data  in  data_width*array_size  lane i occupies bits [(i+1)*data_width-1 : i*data_width]
mem_we  out  1  write strobe
mem_addr  out  addr_width  write address
mem_wdata  out  data_width  write data
mem_ready  in  1  memory accepts the write or slot this cycle; stalls the serializer when low
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset: state IDLE; FIFO emptied; all counters 0; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0. Reset mid-job aborts the job. No write is issued in the reset cycle or the cycle after it.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE->RUN on start if num_vecs!=0.
  - IDLE->DONE on start if num_vecs==0.
  - RUN->DRAIN when acc_cnt reaches num_vecs.
  - DRAIN->DONE when the last lane of the last vector is serialized.
  - DONE->IDLE after one cycle, with done=1 for that cycle.
- in_ready is registered: 1 iff state==RUN, FIFO count<fifo_depth, and acc_cnt<num_vecs.
  - Count is evaluated before this cycle's pop. A full FIFO holds in_ready=0 even while popping; there is no bypass.
- Push and pop in the same cycle leave the count unchanged. FIFO read and write pointers wrap modulo fifo_depth.
- Serializer:
  - Head vector is popped only after lane array_size-1 is consumed.
  - lane_idx advances 0..array_size-1 by one per cycle when mem_ready=1 and the FIFO is non-empty.
  - When mem_ready=0, lane_idx, mem_addr and mem_wdata all hold.
- Write outputs, registered: mem_addr = base + word_cnt (mod 2^addr_width); mem_wdata = the head lane; mem_we = in_en bit of that lane.
- Masked lanes still consume one slot and advance the address, with mem_we=0. Address layout is therefore independent of the mask.
- word_cnt increments per consumed lane, masked or not. Address wraps silently from 2^addr_width-1 to 0.
- Latency: a vector accepted at cycle N gives its lane 0 write on the outputs at cycle N+2 at the earliest (FIFO write, then output register). Sustained throughput is one lane per cycle, i.e. one vector per array_size cycles.
- start while busy or in DONE is ignored. in_valid outside RUN is not accepted.
- Data is passed unmodified; signed values are not altered.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DRAIN/DONE) and the lane-slice helper constant used by both the activation array and this block.
- One sub-module: vec_fifo, a parameterized synchronous FIFO of data_width*array_size+array_size bits with registered count, full and empty.
- The FSM, counters and serializer stay in the top module.

Test Plan:
1. Reset, then start with base=0x100, num_vecs=2. Push vectors lanes 1..9 and 11..19, all en=1, mem_ready=1.
   -> 18 consecutive writes, addr 0x100..0x111, data 1..9 then 11..19. done pulses once, one cycle after the last write.
2. in_en=9'b1_0101_0101 for a single vector at base 0x20.
   -> mem_we high only at addr 0x20, 0x22, 0x24, 0x26, 0x28. Addresses still advance through 0x28.
3. Hold mem_ready=0 for 5 cycles mid-vector (at lane 3).
   -> mem_addr and mem_wdata frozen. Resume at lane 3 with no lost or duplicated lane.
   -> With mem_ready=0 for a long time, the FIFO fills and in_ready drops after 4 vectors are accepted.
4. num_vecs=0 start -> no writes, in_ready stays 0, done pulses 2 cycles after start.
5. base=0xFFC, addr_width=12, one vector -> addresses 0xFFC..0xFFF then 0x000..0x004.
6. Assert reset during lane 5 of vector 1.
   -> Next cycle: mem_we=0, busy=0, in_ready=0.
   -> A new start then operates cleanly from its own base_addr.
